// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard control for the 5-stage pipeline.
// Tracks rd/write/load bits of EX, MEM and WB; registers the EX operand selects.
module fwd_ctrl #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_we
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
    } stage_t;

    // The load flag only matters while the instruction is in EX.
    stage_t ex_q, ex_d;
    stage_t mem_q;
    stage_t wb_q;
    logic   ex_memread_q, ex_memread_d;
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;

    function automatic logic writes_reg(input stage_t s, input logic [REG_ADDR_W-1:0] rs);
        return s.valid && s.regwrite && (s.rd != '0) && (s.rd == rs);
    endfunction

    // Newest producer wins: the EX instruction is one step younger than MEM.
    function automatic logic [1:0] pick_sel(input logic [REG_ADDR_W-1:0] rs,
                                            input stage_t ex, input stage_t mem);
        if (writes_reg(ex, rs)) begin
            return SEL_MEM;
        end else if (writes_reg(mem, rs)) begin
            return SEL_WB;
        end
        return SEL_RF;
    endfunction

    assign stall = id_valid && ex_q.valid && ex_memread_q && (ex_q.rd != '0) &&
                   ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

    always_comb begin
        ex_d         = '0;
        ex_memread_d = 1'b0;
        fwd_a_d      = SEL_RF;
        fwd_b_d      = SEL_RF;
        if (!(flush || stall)) begin
            ex_d.valid    = id_valid;
            ex_d.rd       = id_rd;
            ex_d.regwrite = id_regwrite;
            ex_memread_d  = id_memread;
            if (id_valid) begin
                fwd_a_d = pick_sel(id_rs1, ex_q, mem_q);
                fwd_b_d = pick_sel(id_rs2, ex_q, mem_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            ex_memread_q <= 1'b0;
            fwd_a_q      <= SEL_RF;
            fwd_b_q      <= SEL_RF;
        end else begin
            ex_q         <= ex_d;
            mem_q        <= ex_q;
            wb_q         <= mem_q;
            ex_memread_q <= ex_memread_d;
            fwd_a_q      <= fwd_a_d;
            fwd_b_q      <= fwd_b_d;
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;
    assign wb_rd     = wb_q.rd;
    assign wb_we     = wb_q.valid && wb_q.regwrite && (wb_q.rd != '0);

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed bench for fwd_ctrl: hand-computed selects, stall and WB outputs per cycle.
module tb_fwd_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_regwrite, id_memread, flush;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall;
    logic [4:0] wb_rd;
    logic       wb_we;

    int n_checks = 0;
    int n_fail   = 0;

    fwd_ctrl #(.REG_ADDR_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .stall       (stall),
        .wb_rd       (wb_rd),
        .wb_we       (wb_we)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw, input logic mr);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
        #1;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        repeat (4) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        // reset with a live-looking decode instruction
        drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("rst_fwd_a", fwd_a_sel, 2'b00);
        check_eq("rst_fwd_b", fwd_b_sel, 2'b00);
        check_eq("rst_stall", stall, 1'b0);
        check_eq("rst_wb_we", wb_we, 1'b0);
        check_eq("rst_wb_rd", wb_rd, 5'd0);
        drain();

        // EX->EX: add x5 ; sub rs1=5 rs2=6
        drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 1'b0);
        check_eq("exex_stall", stall, 1'b0);
        tick();
        nop();
        check_eq("exex_fwd_a", fwd_a_sel, 2'b01);
        check_eq("exex_fwd_b", fwd_b_sel, 2'b00);
        tick();
        check_eq("exex_wb_we", wb_we, 1'b1);
        check_eq("exex_wb_rd", wb_rd, 5'd5);
        tick();
        check_eq("exex_wb_rd2", wb_rd, 5'd8);
        drain();

        // MEM->EX: add x7 ; nop ; or rs2=7
        drive(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        tick();
        nop();
        tick();
        drive(1'b1, 5'd1, 5'd7, 5'd9, 1'b1, 1'b0);
        tick();
        nop();
        check_eq("memex_fwd_a", fwd_a_sel, 2'b00);
        check_eq("memex_fwd_b", fwd_b_sel, 2'b10);
        drain();

        // priority: add x7 ; add x7 ; reader x7 on both operands
        drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd7, 5'd7, 5'd10, 1'b1, 1'b0);
        tick();
        nop();
        check_eq("prio_fwd_a", fwd_a_sel, 2'b01);
        check_eq("prio_fwd_b", fwd_b_sel, 2'b01);
        drain();

        // load-use: lw x3 ; add rs1=3 rs2=4
        drive(1'b1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, 1'b0);
        check_eq("lu_stall_on", stall, 1'b1);
        tick();
        check_eq("lu_stall_off", stall, 1'b0);
        check_eq("lu_bubble_a", fwd_a_sel, 2'b00);
        tick();
        nop();
        check_eq("lu_fwd_a", fwd_a_sel, 2'b10);
        check_eq("lu_fwd_b", fwd_b_sel, 2'b00);
        check_eq("lu_stall_ex", stall, 1'b0);
        check_eq("lu_wb_load_we", wb_we, 1'b1);
        check_eq("lu_wb_load_rd", wb_rd, 5'd3);
        tick();
        check_eq("lu_wb_bubble", wb_we, 1'b0);
        tick();
        check_eq("lu_wb_add_we", wb_we, 1'b1);
        check_eq("lu_wb_add_rd", wb_rd, 5'd9);
        drain();

        // x0: lw x0 ; reader of x0
        drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0);
        check_eq("x0_stall", stall, 1'b0);
        tick();
        nop();
        check_eq("x0_fwd_a", fwd_a_sel, 2'b00);
        check_eq("x0_fwd_b", fwd_b_sel, 2'b00);
        tick();
        check_eq("x0_wb_we", wb_we, 1'b0);
        drain();

        // flush during load-use stall
        drive(1'b1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, 1'b0);
        flush = 1'b1;
        check_eq("fl_stall", stall, 1'b1);
        tick();
        flush = 1'b0;
        nop();
        check_eq("fl_fwd_a", fwd_a_sel, 2'b00);
        check_eq("fl_fwd_b", fwd_b_sel, 2'b00);
        tick();
        check_eq("fl_wb_load", wb_we, 1'b1);
        tick();
        check_eq("fl_wb_slot", wb_we, 1'b0);
        drain();

        // flush alone squashes a producer: no forward, no writeback
        drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b1, 5'd5, 5'd0, 5'd11, 1'b0, 1'b0);
        tick();
        nop();
        check_eq("fl2_fwd_a", fwd_a_sel, 2'b00);
        tick();
        check_eq("fl2_wb_we", wb_we, 1'b0);
        drain();

        // reset mid-stream: load in EX, consumer in decode
        drive(1'b1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, 1'b0);
        check_eq("mr_stall_pre", stall, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("mr_stall_post", stall, 1'b0);
        check_eq("mr_wb_we0", wb_we, 1'b0);
        nop();
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_eq($sformatf("mr_wb_we%0d", i), wb_we, 1'b0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_ctrl.md
# fwd_ctrl

Forwarding and load-use hazard controller for the 5-stage RISC-V pipeline. It tracks the destination register, write-enable and load flag of the instructions in EX, MEM and WB. It produces the registered 2-bit select for the two EX-stage `mux31` operand multiplexers and a combinational stall request for fetch/decode. It carries no data, only register indices and control bits.

## Interface

Parameters:
- `REG_ADDR_W`, default 5: register index width.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `id_valid` in 1: decode holds a real instruction.
- `id_rs1`, `id_rs2` in `REG_ADDR_W`: source indices of the decode instruction.
- `id_rd` in `REG_ADDR_W`: destination index of the decode instruction.
- `id_regwrite` in 1: decode instruction writes `rd`.
- `id_memread` in 1: decode instruction is a load.
- `flush` in 1: squash; inject a bubble into EX this edge.
- `fwd_a_sel`, `fwd_b_sel` out 2: operand mux selects for the EX instruction.
  - `00`: register file (mux input a).
  - `01`: EX/MEM ALU result (mux input b).
  - `10`: MEM/WB writeback value (mux input c).
  - `11` is never driven.
- `stall` out 1: load-use hazard; hold PC and IF/ID.
- `wb_rd` out `REG_ADDR_W`: destination index of the WB instruction.
- `wb_we` out 1: WB instruction writes the register file (`wb_valid & wb_regwrite`, with `wb_rd != 0`).

## Operation

- Stage records EX, MEM and WB each hold `{valid, rd, regwrite, memread}`. On every edge MEM←EX and WB←MEM, unconditionally.
- EX load, highest priority first:
  - `flush`: EX←bubble (`valid=0`); both selects←`00`.
  - else `stall`: EX←bubble; both selects←`00`.
  - else EX←`{id_valid, id_rd, id_regwrite, id_memread}`; selects computed as below.
- Select for operand A (same rule for B using `id_rs2`):
  - `01` if `ex_valid & ex_regwrite & ex_rd != 0 & ex_rd == id_rs1`. The current EX instruction will be in MEM.
  - else `10` if `mem_valid & mem_regwrite & mem_rd != 0 & mem_rd == id_rs1`. The current MEM instruction will be in WB.
  - else `00`.
  - The EX match takes priority over the MEM match: the newest producer wins.
  - If `id_valid=0`, both selects←`00`.
- `stall` = `id_valid & ex_valid & ex_memread & ex_rd != 0 & (ex_rd == id_rs1 | ex_rd == id_rs2)`.
  - Exactly one stall cycle per load-use pair.
  - After the bubble the load sits in MEM, so the consumer receives select `10` on its next attempt.
- Index 0 is never forwarded, never stalls on, and never asserts `wb_we`.
- A write by the WB instruction to the register being read in decode is resolved by the register file's write-before-read behaviour, not by this block.

## Timing

- Reset: on an edge with `rst_n=0`, all stage valids←0, `rd`/flags←0, selects←`00`.
  - Consequently `stall=0`, `wb_we=0` and `wb_rd=0` in the first cycle after reset.
  - Reset mid-stream discards all tracked instructions. No forward or stall refers to a pre-reset instruction.
- Selects are registered. They are valid throughout the cycle in which their instruction occupies EX, i.e. one edge after the decode presentation.
- `stall` is combinational from EX state and decode inputs, so it is valid in the same cycle.
- `wb_rd`/`wb_we` are combinational from the WB record, and valid in the cycle the instruction occupies WB.
- `flush` and `stall` asserted together: flush wins. The result is identical (bubble, selects `00`), and upstream discards the decode instruction.
- Back-to-back producers writing the same `rd` (EX and MEM both match): select `01`.

## Test plan

- **Reset:** hold `rst_n=0` 2 cycles with `id_valid=1`, `id_rs1=id_rd=5`, `id_regwrite=1` → `fwd_a_sel=00`, `stall=0`, `wb_we=0` in the cycle after release.
- **EX→EX forward:** `add x5` then `sub` reading `rs1=5`, `rs2=6` on consecutive cycles → `sub` in EX shows `fwd_a_sel=01`, `fwd_b_sel=00`.
- **MEM→EX forward and priority:**
  - `add x7`, nop, `or` reading `rs2=7` → `fwd_b_sel=10`.
  - `add x7`, `add x7`, reader of `x7` → `01`.
- **Load-use:** `lw x3` then `add` reading `rs1=3` → `stall=1` for exactly one cycle, EX bubble, then `add` in EX with `fwd_a_sel=10`, `stall=0`.
- **x0 and flush:**
  - writer with `rd=0` followed by a reader of `x0` → selects `00`, no stall, `wb_we=0` three edges later.
  - `flush=1` during a load-use stall → EX bubble, selects `00`, no instruction reaches WB for that slot.
- **Reset mid-operation:** assert `rst_n=0` for one edge while the load is in EX and the consumer is in decode → `stall=0` next cycle, and `wb_we` stays 0 for the following three cycles.
